// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-bit TDM mux/demux pair.
// Holds the slot-alignment state encoding and the default data and counter widths.
// The mux testbench also uses TDM_WIDTH, so keep the constants stable.
package tdm_pkg;

   localparam int TDM_WIDTH = 4;
   localparam int TDM_CNT_W = 8;

   // HUNT: no alignment; EXP1: slot 0 taken, slot 1 expected; EXP0: aligned, slot 0 expected
   typedef enum logic [1:0] {
      HUNT = 2'd0,
      EXP1 = 2'd1,
      EXP0 = 2'd2
   } tdm_state_e;

endpackage

// File: rtl/tdm_slot_fsm.sv
// Slot-alignment FSM for the TDM demux. It decodes capture enables and error/frame events.
// Latency: the enables are combinational from the current state and inputs; the pulses and sel_out are registered (1 cycle).
// Backpressure: none. Only cycles with in_valid=1 advance the state.
// Ports: clk/rst_n; in_valid and frame_start in; cap0_en/cap1_en/frame_done/err_det
//        (same-cycle decode for the top's registers); sel_out and the out_valid0/1,
//        pair_valid and err_frame registered pulses.
module tdm_slot_fsm
   import tdm_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic frame_start,
   output logic cap0_en,
   output logic cap1_en,
   output logic frame_done,
   output logic err_det,
   output logic sel_out,
   output logic out_valid0,
   output logic out_valid1,
   output logic pair_valid,
   output logic err_frame
);

   tdm_state_e state_q, state_d;

   always_comb begin
      state_d    = state_q;
      cap0_en    = 1'b0;
      cap1_en    = 1'b0;
      frame_done = 1'b0;
      err_det    = 1'b0;
      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (frame_start) begin
                  cap0_en = 1'b1;
                  state_d = EXP1;
               end
            end
            EXP1: begin
               if (frame_start) begin
                  // Slot 1 went missing: treat this word as a fresh slot 0
                  err_det = 1'b1;
                  cap0_en = 1'b1;
               end else begin
                  cap1_en    = 1'b1;
                  frame_done = 1'b1;
                  state_d    = EXP0;
               end
            end
            EXP0: begin
               if (frame_start) begin
                  cap0_en = 1'b1;
                  state_d = EXP1;
               end else begin
                  // Marker missing: alignment is lost, so nothing is captured
                  err_det = 1'b1;
                  state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         sel_out    <= 1'b0;
         out_valid0 <= 1'b0;
         out_valid1 <= 1'b0;
         pair_valid <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_out    <= (state_d == EXP1);
         out_valid0 <= cap0_en;
         out_valid1 <= cap1_en;
         pair_valid <= frame_done;
         err_frame  <= err_det;
      end
   end

endmodule

// File: rtl/tdm_demux_12_4bit.sv
// 2-slot TDM demux: splits an aligned 4-bit slot stream into two registered channels.
// Latency: 1 cycle from an accepted word to its outputs. A full frame takes every 2 valid cycles with no bubbles.
// Backpressure: none. in_valid=0 cycles hold all state. Optional error counter: define TDM_DEMUX_ERR_CNT_EN.
// Ports: clk/rst_n; demux_in/in_valid/frame_start in; demux_out0/1 with out_valid0/1,
//        pair_valid, sel_out, err_frame, frame_cnt (wrapping), err_cnt (saturating or tied 0).
module tdm_demux_12_4bit
   import tdm_pkg::*;
#(
   parameter int WIDTH = TDM_WIDTH,
   parameter int CNT_W = TDM_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] demux_in,
   input  logic             in_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] demux_out0,
   output logic [WIDTH-1:0] demux_out1,
   output logic             out_valid0,
   output logic             out_valid1,
   output logic             pair_valid,
   output logic             sel_out,
   output logic             err_frame,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic cap0_en, cap1_en, frame_done, err_det;

   logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   tdm_slot_fsm u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .frame_start (frame_start),
      .cap0_en     (cap0_en),
      .cap1_en     (cap1_en),
      .frame_done  (frame_done),
      .err_det     (err_det),
      .sel_out     (sel_out),
      .out_valid0  (out_valid0),
      .out_valid1  (out_valid1),
      .pair_valid  (pair_valid),
      .err_frame   (err_frame)
   );

   always_comb begin
      out0_d      = cap0_en ? demux_in : out0_q;
      out1_d      = cap1_en ? demux_in : out1_q;
      // frame_cnt wraps naturally at 2^CNT_W
      frame_cnt_d = frame_done ? frame_cnt_q + CNT_ONE : frame_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out0_q      <= '0;
         out1_q      <= '0;
         frame_cnt_q <= '0;
      end else begin
         out0_q      <= out0_d;
         out1_q      <= out1_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign demux_out0 = out0_q;
   assign demux_out1 = out1_q;
   assign frame_cnt  = frame_cnt_q;

`ifdef TDM_DEMUX_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Saturates at all-ones and clears only on reset
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_det && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_err_det;
   assign unused_err_det = err_det;
   assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_tdm_demux_12_4bit.sv
// Self-checking bench for tdm_demux_12_4bit. It uses a scoreboard fed by a behavioural reference model.
// Each driven word pushes its expected post-edge outputs to a queue. The queue is popped one cycle later.
// The expected err_cnt follows the TDM_DEMUX_ERR_CNT_EN build option.
module tb_tdm_demux_12_4bit;

   typedef struct packed {
      logic [3:0] out0;
      logic [3:0] out1;
      logic       v0;
      logic       v1;
      logic       pair;
      logic       sel;
      logic       err;
      logic [7:0] fcnt;
      logic [7:0] ecnt;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] demux_in;
   logic       in_valid;
   logic       frame_start;
   logic [3:0] demux_out0, demux_out1;
   logic       out_valid0, out_valid1, pair_valid, sel_out, err_frame;
   logic [7:0] frame_cnt, err_cnt;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   // Reference model state: 0=HUNT, 1=EXP1, 2=EXP0
   int         m_state;
   logic [3:0] m_out0, m_out1;
   logic [7:0] m_fcnt, m_ecnt;

   tdm_demux_12_4bit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .demux_in    (demux_in),
      .in_valid    (in_valid),
      .frame_start (frame_start),
      .demux_out0  (demux_out0),
      .demux_out1  (demux_out1),
      .out_valid0  (out_valid0),
      .out_valid1  (out_valid1),
      .pair_valid  (pair_valid),
      .sel_out     (sel_out),
      .err_frame   (err_frame),
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_out0  = '0;
      m_out1  = '0;
      m_fcnt  = '0;
      m_ecnt  = '0;
   endtask

   function automatic exp_t snap(input logic v0, v1, pair, err);
      exp_t e;
      e.out0 = m_out0;
      e.out1 = m_out1;
      e.v0   = v0;
      e.v1   = v1;
      e.pair = pair;
      e.sel  = (m_state == 1);
      e.err  = err;
      e.fcnt = m_fcnt;
      e.ecnt = m_ecnt;
      return e;
   endfunction

   task automatic compare_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, ".out0"}, 32'(demux_out0), 32'(e.out0));
      chk({tag, ".out1"}, 32'(demux_out1), 32'(e.out1));
      chk({tag, ".v0"},   32'(out_valid0), 32'(e.v0));
      chk({tag, ".v1"},   32'(out_valid1), 32'(e.v1));
      chk({tag, ".pair"}, 32'(pair_valid), 32'(e.pair));
      chk({tag, ".sel"},  32'(sel_out),    32'(e.sel));
      chk({tag, ".err"},  32'(err_frame),  32'(e.err));
      chk({tag, ".fcnt"}, 32'(frame_cnt),  32'(e.fcnt));
      chk({tag, ".ecnt"}, 32'(err_cnt),    32'(e.ecnt));
   endtask

   // Drive one cycle, predict the outputs after the next edge, then check them
   task automatic drive(input string tag, input logic v, input logic fs, input logic [3:0] d);
      logic p0, p1, pp, pe;
      demux_in    = d;
      in_valid    = v;
      frame_start = fs;
      p0 = 0; p1 = 0; pp = 0; pe = 0;
      if (v) begin
         case (m_state)
            0: if (fs) begin m_out0 = d; p0 = 1; m_state = 1; end
            1: if (fs) begin
                  pe = 1; m_out0 = d; p0 = 1;
               end else begin
                  m_out1 = d; p1 = 1; pp = 1; m_fcnt = m_fcnt + 8'd1; m_state = 2;
               end
            default: if (fs) begin
                  m_out0 = d; p0 = 1; m_state = 1;
               end else begin
                  pe = 1; m_state = 0;
               end
         endcase
`ifdef TDM_DEMUX_ERR_CNT_EN
         if (pe && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
`endif
      end
      sb.push_back(snap(p0, p1, pp, pe));
      @(posedge clk);
      #1;
      compare_out(tag);
   endtask

   // Asynchronous reset pulse placed mid-cycle, with outputs checked while reset is held
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      sb.push_back(snap(0, 0, 0, 0));
      compare_out(tag);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      demux_in    = '0;
      in_valid    = 1'b0;
      frame_start = 1'b0;
      model_reset();
      #12;
      sb.push_back(snap(0, 0, 0, 0));
      compare_out("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Unaligned non-start word out of reset is discarded silently
      drive("hunt_discard", 1, 0, 4'd11);
      drive("idle", 0, 1, 4'd6);

      // Single frame 15/1
      drive("f1_s0", 1, 1, 4'd15);
      drive("f1_s1", 1, 0, 4'd1);
      drive("idle2", 0, 0, 4'd3);

      // Back-to-back frames
      drive("b2b_s0a", 1, 1, 4'd14);
      drive("b2b_s1a", 1, 0, 4'd2);
      drive("b2b_s0b", 1, 1, 4'd13);
      drive("b2b_s1b", 1, 0, 4'd3);
      drive("b2b_s0c", 1, 1, 4'd12);
      drive("b2b_s1c", 1, 0, 4'd4);

      // Missing marker in EXP0, then HUNT discards a non-start word
      drive("exp0_err", 1, 0, 4'd8);
      drive("hunt_after_err", 1, 0, 4'd10);

      // Missing slot 1: restart 5 -> 7, then 9 completes the frame
      drive("ms_s0", 1, 1, 4'd5);
      drive("ms_restart", 1, 1, 4'd7);
      drive("ms_s1", 1, 0, 4'd9);

      // Reset mid-frame drops the half frame; the next non-start word is ignored
      drive("rst_s0", 1, 1, 4'd6);
      async_reset("rst_mid");
      drive("rst_after", 1, 0, 4'd2);

      // frame_cnt wraps after 256 frames; valid gaps are interleaved
      for (int i = 0; i < 257; i++) begin
         drive("wrap_s0", 1, 1, 4'(i));
         if (i % 7 == 0) drive("wrap_gap", 0, 0, 4'd0);
         drive("wrap_s1", 1, 0, 4'(i + 3));
      end

      // Repeated starts: sustained errors drive the err counter into saturation when it is enabled
      async_reset("rst_sat");
      for (int i = 0; i < 300; i++) begin
         drive("sat", 1, 1, 4'(i));
      end
      drive("sat_end", 1, 0, 4'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
